// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO register map, STATUS layout, lane width.
// No logic of its own; latency n/a.
// Backpressure n/a.
package dmem_pkg;

    localparam int LANE_W = 8;
    localparam int LANES  = 4;

    // Word offsets inside the 16-byte MMIO window
    localparam logic [1:0] OFF_CONSOLE_TX = 2'd0;
    localparam logic [1:0] OFF_STATUS     = 2'd1;
    localparam logic [1:0] OFF_CYCLE_LO   = 2'd2;
    localparam logic [1:0] OFF_CYCLE_HI   = 2'd3;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 4;

    function automatic logic [31:0] status_word(input logic       full,
                                                input logic       empty,
                                                input logic       ovf,
                                                input logic [3:0] cnt);
        logic [31:0] w;
        w                  = '0;
        w[ST_FULL]         = full;
        w[ST_EMPTY]        = empty;
        w[ST_OVF]          = ovf;
        w[ST_CNT_LSB +: 4] = cnt;
        return w;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small byte FIFO for the console TX path; head is shown combinationally from storage.
// Latency: a pushed byte is visible at the head one edge after the push (when it lands in an empty FIFO).
// Backpressure: push while full is accepted only if a pop happens the same edge, otherwise it is dropped and flagged.
module byte_fifo
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = LANE_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = 1;
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_pop;
    logic          do_push;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop on the same edge frees the slot a full-FIFO push needs
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign head_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-memory responder: byte-lane RAM plus console FIFO, cycle counter and status MMIO window.
// Latency: every access reads; data_mem_read_o is registered, valid one edge after the address is sampled.
// Backpressure: none on the CPU side; console drain is valid/ready, bytes pushed into a full FIFO are dropped.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int          MEM_DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE       = 32'h0001_0000,
    parameter int          FIFO_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  data_mem_we_i,
    input  logic [31:0] data_mem_address_i,
    input  logic [31:0] data_mem_write_i,
    output logic [31:0] data_mem_read_o,
    output logic [7:0]  console_data_o,
    output logic        console_valid_o,
    input  logic        console_ready_i
);

    localparam int          AW        = $clog2(MEM_DEPTH_WORDS);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_DEPTH_WORDS);

    logic [31:0]   ram [MEM_DEPTH_WORDS];
    logic [31:0]   word_addr;
    logic [31:0]   mmio_rel;
    logic [AW-1:0] ram_idx;
    logic [1:0]    mmio_off;
    logic          is_ram;
    logic          is_mmio;

    logic [63:0]   cycle_cnt;
    logic [31:0]   hi_shadow;
    logic          ovf_flag;
    logic [31:0]   rd_next;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_drop;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_head;

    logic          lo_access;
    logic          cnt_clr;
    logic          ovf_clr;

    assign word_addr = data_mem_address_i & 32'hFFFF_FFFC;
    // Offset from the window base; unsigned wrap makes addresses below the base fall out of range
    assign mmio_rel  = word_addr - MMIO_BASE;
    assign is_ram    = (word_addr < RAM_BYTES);
    assign is_mmio   = (mmio_rel < 32'd16);
    assign ram_idx   = word_addr[AW+1:2];
    assign mmio_off  = mmio_rel[3:2];

    assign lo_access = is_mmio && (mmio_off == OFF_CYCLE_LO);
    assign cnt_clr   = lo_access && (|data_mem_we_i);
    assign ovf_clr   = is_mmio && (mmio_off == OFF_STATUS) && data_mem_we_i[0]
                       && data_mem_write_i[ST_OVF];
    assign fifo_push = is_mmio && (mmio_off == OFF_CONSOLE_TX) && data_mem_we_i[0];
    assign fifo_pop  = console_valid_o && console_ready_i;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (LANE_W)
    ) u_console_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_dat (data_mem_write_i[7:0]),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .drop     (fifo_drop)
    );

    assign console_valid_o = !fifo_empty;
    assign console_data_o  = fifo_head;

    // Reads see register/RAM state before this edge's updates (read-first)
    always_comb begin
        rd_next = '0;
        if (is_ram) begin
            rd_next = ram[ram_idx];
        end else if (is_mmio) begin
            unique case (mmio_off)
                OFF_STATUS:   rd_next = status_word(fifo_full, fifo_empty, ovf_flag, 4'(fifo_count));
                OFF_CYCLE_LO: rd_next = cycle_cnt[31:0];
                OFF_CYCLE_HI: rd_next = hi_shadow;
                default:      rd_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (is_ram) begin
            for (int k = 0; k < LANES; k++) begin
                if (data_mem_we_i[k]) ram[ram_idx][k*LANE_W +: LANE_W] <= data_mem_write_i[k*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_mem_read_o <= '0;
            cycle_cnt       <= '0;
            hi_shadow       <= '0;
            ovf_flag        <= 1'b0;
        end else begin
            data_mem_read_o <= rd_next;
            cycle_cnt       <= cnt_clr ? 64'd0 : cycle_cnt + 64'd1;
            if (lo_access) hi_shadow <= cycle_cnt[63:32];
            if (fifo_drop)    ovf_flag <= 1'b1;
            else if (ovf_clr) ovf_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios with literal expectations, then random traffic
// compared every cycle against a queue/array model of the memory map.
module tb_data_mem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] MB    = 32'h0001_0000;
    localparam int          FD    = 4;
    localparam logic [31:0] IDLE  = 32'h0002_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  we = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdat = '0;
    logic        rdy = 1'b0;
    logic [31:0] data_mem_read_o;
    logic [7:0]  console_data_o;
    logic        console_valid_o;

    data_mem_responder #(
        .MEM_DEPTH_WORDS (DEPTH),
        .MMIO_BASE       (MB),
        .FIFO_DEPTH      (FD)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .data_mem_we_i      (we),
        .data_mem_address_i (addr),
        .data_mem_write_i   (wdat),
        .data_mem_read_o    (data_mem_read_o),
        .console_data_o     (console_data_o),
        .console_valid_o    (console_valid_o),
        .console_ready_i    (rdy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_ram [DEPTH];
    logic [3:0]  m_kn  [DEPTH];
    logic [7:0]  m_q[$];
    bit          m_ovf;
    logic [63:0] m_ctr;
    logic [31:0] m_shadow;
    logic [31:0] exp_rd;
    bit          exp_rd_known = 1'b0;
    bit          exp_valid = 1'b0;
    logic [7:0]  exp_head;

    task automatic model_edge();
        logic [31:0] a;
        logic [31:0] rel;
        int          idx;
        int          off;
        bit          ram_hit;
        bit          mmio_hit;
        if (reset) begin
            m_q.delete();
            m_ovf = 0; m_ctr = 0; m_shadow = 0;
            exp_rd = 0; exp_rd_known = 1; exp_valid = 0; exp_head = 0;
            return;
        end
        a        = addr & 32'hFFFF_FFFC;
        rel      = a - MB;
        ram_hit  = (a < 32'(4*DEPTH));
        mmio_hit = !ram_hit && (rel < 16);
        idx      = int'(a >> 2);
        off      = int'(rel >> 2);
        exp_rd = 0; exp_rd_known = 1;
        if (ram_hit) begin
            exp_rd = m_ram[idx];
            exp_rd_known = (m_kn[idx] == 4'hF);
        end else if (mmio_hit) begin
            case (off)
                1: begin
                    exp_rd[0]   = (m_q.size() == FD);
                    exp_rd[1]   = (m_q.size() == 0);
                    exp_rd[2]   = m_ovf;
                    exp_rd[7:4] = 4'(m_q.size());
                end
                2: exp_rd = m_ctr[31:0];
                3: exp_rd = m_shadow;
                default: exp_rd = 0;
            endcase
        end
        if (ram_hit) begin
            for (int k = 0; k < 4; k++) begin
                if (we[k]) begin
                    m_ram[idx][8*k +: 8] = wdat[8*k +: 8];
                    m_kn[idx][k] = 1'b1;
                end
            end
        end
        if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
        if (mmio_hit && off == 0 && we[0]) begin
            if (m_q.size() < FD) m_q.push_back(wdat[7:0]);
            else m_ovf = 1;
        end
        if (mmio_hit && off == 1 && we[0] && wdat[2]) m_ovf = 0;
        if (mmio_hit && off == 2) m_shadow = m_ctr[63:32];
        if (mmio_hit && off == 2 && we != 0) m_ctr = 0;
        else m_ctr = m_ctr + 64'd1;
        exp_valid = (m_q.size() != 0);
        exp_head  = exp_valid ? m_q[0] : 8'h00;
    endtask

    // Single compare process: model advances on each edge, outputs checked 1 time unit later
    always @(posedge clk) begin
        model_edge();
        #1;
        if (exp_rd_known) check("rd_model", data_mem_read_o, exp_rd);
        check("valid_model", 32'(console_valid_o), 32'(exp_valid));
        if (exp_valid) check("head_model", 32'(console_data_o), 32'(exp_head));
    end

    task automatic op(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d, input logic r);
        @(negedge clk);
        we = w; addr = a; wdat = d; rdy = r;
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_kn[i] = 4'h0;
            m_ram[i] = '0;
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("reset_rd", data_mem_read_o, 32'h0);
        check("reset_valid", 32'(console_valid_o), 32'h0);
        check("reset_data", 32'(console_data_o), 32'h0);
        @(negedge clk) reset = 1'b0;

        // Byte-lane store
        op(4'hF, 32'h10, 32'hDEAD_BEEF, 0);
        op(4'b0010, 32'h10, 32'h0000_5500, 0);
        op(4'h0, 32'h10, 32'h0, 0);
        check("byte_lane", data_mem_read_o, 32'hDEAD_55EF);

        // Read-first on same-word read/write
        op(4'hF, 32'h20, 32'h0, 0);
        op(4'hF, 32'h20, 32'h1234_5678, 0);
        check("read_first_old", data_mem_read_o, 32'h0);
        op(4'h0, 32'h20, 32'h0, 0);
        check("read_first_new", data_mem_read_o, 32'h1234_5678);

        // FIFO fill / overflow / drain
        for (int i = 0; i < 4; i++) op(4'h1, MB, 32'h41 + 32'(i), 0);
        op(4'h0, MB + 4, 0, 0);
        check("status_full", data_mem_read_o, 32'h41);
        op(4'h1, MB, 32'h45, 0);
        op(4'h0, MB + 4, 0, 0);
        check("status_ovf", data_mem_read_o, 32'h45);
        for (int i = 0; i < 4; i++) begin
            check("drain_head", 32'(console_data_o), 32'h41 + 32'(i));
            op(4'h0, IDLE, 0, 1);
        end
        check("drain_valid_low", 32'(console_valid_o), 32'h0);
        op(4'h0, MB + 4, 0, 0);
        check("status_empty_ovf", data_mem_read_o, 32'h06);
        op(4'h1, MB + 4, 32'h4, 0);
        op(4'h0, MB + 4, 0, 0);
        check("status_ovf_clr", data_mem_read_o, 32'h02);

        // Push+pop while full
        for (int i = 0; i < 4; i++) op(4'h1, MB, 32'h61 + 32'(i), 0);
        op(4'h1, MB, 32'h5A, 1);
        op(4'h0, MB + 4, 0, 0);
        check("status_full_pp", data_mem_read_o, 32'h41);
        begin
            logic [7:0] seq [4];
            seq[0] = 8'h62; seq[1] = 8'h63; seq[2] = 8'h64; seq[3] = 8'h5A;
            for (int i = 0; i < 4; i++) begin
                check("pp_head", 32'(console_data_o), 32'(seq[i]));
                op(4'h0, IDLE, 0, 1);
            end
        end
        check("pp_valid_low", 32'(console_valid_o), 32'h0);

        // Counter clear: reads 0 in the cycle after the clear edge, so 10 cycles later it reads 10
        op(4'h4, MB + 8, 0, 0);
        repeat (10) op(4'h0, IDLE, 0, 0);
        op(4'h0, MB + 8, 0, 0);
        check("cycle_lo_10", data_mem_read_o, 32'd10);

        // Carry across the low word: HI returns the shadow latched by the LO read
        @(negedge clk);
        force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFE;
        m_ctr = 64'h0000_0000_FFFF_FFFE;
        we = 0; addr = MB + 8; wdat = 0; rdy = 0;
        #1 release dut.cycle_cnt;
        @(posedge clk);
        #2;
        check("carry_lo", data_mem_read_o, 32'hFFFF_FFFE);
        op(4'h0, IDLE, 0, 0);
        op(4'h0, MB + 12, 0, 0);
        check("carry_hi_shadow", data_mem_read_o, 32'h0);
        op(4'h0, MB + 8, 0, 0);
        check("carry_lo2", data_mem_read_o, 32'h1);
        op(4'h0, MB + 12, 0, 0);
        check("carry_hi_new", data_mem_read_o, 32'h1);

        // Unmapped and boundary addresses
        op(4'hF, IDLE, 32'hFFFF_FFFF, 0);
        op(4'h0, IDLE, 0, 0);
        check("unmapped", data_mem_read_o, 32'h0);
        op(4'hF, 32'h0000_0FFC, 32'hCAFE_F00D, 0);
        op(4'h0, 32'h0000_0FFE, 0, 0);
        check("ram_last_word", data_mem_read_o, 32'hCAFE_F00D);
        op(4'h0, 32'h0000_1000, 0, 0);
        check("ram_end_unmapped", data_mem_read_o, 32'h0);
        op(4'h0, MB + 16, 0, 0);
        check("mmio_end_unmapped", data_mem_read_o, 32'h0);
        op(4'h0, 32'h0000_0013, 0, 0);
        check("low_bits_ignored", data_mem_read_o, 32'hDEAD_55EF);

        // Reset mid-drain with 3 bytes queued
        for (int i = 0; i < 4; i++) op(4'h1, MB, 32'h71 + 32'(i), 0);
        op(4'h0, 32'h10, 0, 1);
        check("pre_reset_head", 32'(console_data_o), 32'h72);
        @(negedge clk);
        reset = 1'b1; rdy = 0;
        #1;
        check("mid_reset_valid", 32'(console_valid_o), 32'h0);
        check("mid_reset_rd", data_mem_read_o, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        op(4'h0, MB + 4, 0, 0);
        check("post_reset_status", data_mem_read_o, 32'h02);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int          kind;
            logic [31:0] a;
            logic [3:0]  w;
            kind = int'($urandom_range(0, 9));
            if (kind < 5)
                a = {20'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)), 4'h0} | 32'($urandom_range(0, 15));
            else if (kind < 9)
                a = MB + 32'($urandom_range(0, 15));
            else
                a = 32'h0000_1000 + 32'($urandom_range(0, 255));
            w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            if (a == MB + 8 || a[31:2] == (MB + 8) >> 2) begin
                if ($urandom_range(0, 7) != 0) w = 4'h0;
            end
            op(w, a, $urandom, 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
